sorted_stream_unloader: RTL and testbench
=========================================

// Module: sorted_stream_unloader
// PURPOSE
//  Downstream stage of the brick sorting network top. Captures each sorted
//  parallel vector (y/y_valid) into a two-bank ping-pong buffer and replays it
//  as a serial element stream with valid/ready handshake and a last marker.
//  Decouples the non-stallable sorter from a consumer that can backpressure.
// PARAMETERS
//  LOG_INPUT_NUM  4   log2 of elements per vector (N = 2**LOG_INPUT_NUM)
//  DATA_WIDTH     32  bits per element
//  LSB_FIRST      1   1: element 0 (bits [DATA_WIDTH-1:0]) streamed first; 0: element N-1 first
// PORTS
//  clk          in   1               clock, all state on rising edge
//  rst          in   1               asynchronous, active-low reset
//  in_valid     in   1               sorter y_valid; one-cycle pulse per vector
//  in_data      in   N*DATA_WIDTH    sorter y, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//  in_ready     out  1               advisory: 1 when at least one bank is free
//  out_valid    out  1               element on out_data valid
//  out_ready    in   1               consumer accepts element when out_valid && out_ready
//  out_data     out  DATA_WIDTH      current element
//  out_last     out  1               high with final element of a vector
//  overflow     out  1               sticky: a vector arrived with both banks full
//  out_idx      out  LOG_INPUT_NUM   element index (only with SORT_UNLOAD_IDX_EN)
// BEHAVIOUR
//  - Reset (rst=0, async): both banks empty, wr_bank=0, rd_bank=0, elem_cnt=0;
//    out_valid=0, out_last=0, out_data=0, overflow=0, in_ready=1.
//  - Capture: in_valid && a bank free -> in_data written to bank wr_bank, bank marked
//    full, wr_bank toggles. Capture takes effect at the rising edge where in_valid is sampled.
//  - Latency: vector captured at edge k into an empty buffer -> out_valid=1 with the first
//    element during the cycle following edge k (one clock). out_data is a registered
//    output; out_valid is derived from bank state.
//  - Read FSM per bank: IDLE (no full bank) -> STREAM (out_valid=1). Handshake advances
//    elem_cnt; out_data holds while out_valid && !out_ready. elem_cnt==N-1 -> out_last=1;
//    handshake on last: bank freed, rd_bank toggles, elem_cnt=0; next bank full -> stay
//    STREAM with no bubble, else IDLE.
//  - Element order: LSB_FIRST=1 streams index 0..N-1, else N-1..0. out_last tracks position.
//  - Both banks full and in_valid: vector dropped, overflow set, held until reset.
//    Exception: same-edge last-element handshake frees a bank -> vector accepted into it,
//    no overflow.
//  - in_valid on consecutive cycles is legal; each pulse is a separate vector.
//  - Reset mid-stream discards all buffered data immediately; no partial output resumes.
// CONFIGURATION
//  SORT_UNLOAD_IDX_EN defined: out_idx port present = source element index of out_data
//    (0..N-1, follows LSB_FIRST), registered alongside out_data, reset 0.
//  Undefined: port absent, no index register; all other behaviour identical.
// STRUCTURE
//  Shared package sort_net_pkg: element count localparam N, element width, bank-index type,
//    elem_cnt width LOG_INPUT_NUM.
//  One sub-module: unload_bank (single N*DATA_WIDTH register + full flag + element mux),
//    instantiated twice; the top holds pointers, elem_cnt, FSM and overflow.
// TESTING
//  1 Reset, one vector {0..15} with out_ready=1 -> 16 beats 0..15 on consecutive cycles,
//    first beat one cycle after in_valid, out_last on beat 15 only, overflow=0.
//  2 LSB_FIRST=0, same vector -> beats 15..0, out_last on value 0.
//  3 Two vectors back-to-back (A then B), out_ready=1 -> 32 beats, no gap between A[15] and B[0].
//  4 out_ready=0, three vectors -> first two buffered, third dropped, overflow=1 and sticky;
//    release out_ready -> only A then B appear.
//  5 Third vector pulsed on the same edge as the last-beat handshake of A -> accepted, no overflow.
//  6 Assert rst mid-stream (beat 7) -> out_valid=0 asynchronously; after release, a new vector
//    streams from element 0; with SORT_UNLOAD_IDX_EN, out_idx matches 0..15.

Source files
------------

// File: rtl/sort_net_pkg.sv
// Shared types and defaults for the sorting-network output stage.
// Holds the element geometry defaults, bank selector type and read FSM encoding.
package sort_net_pkg;

    localparam int LOG_INPUT_NUM_DEF = 4;
    localparam int DATA_WIDTH_DEF    = 32;

    typedef logic bank_sel_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    function automatic int elem_count(input int log_n);
        return 1 << log_n;
    endfunction

endpackage

// File: rtl/unload_bank.sv
// One ping-pong bank: a full-vector register with its occupancy flag and an
// element select mux reading the currently stored vector.
module unload_bank
    import sort_net_pkg::*;
#(
    parameter int LOG_INPUT_NUM = LOG_INPUT_NUM_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        wr_en,
    input  logic [(2**LOG_INPUT_NUM)*DATA_WIDTH-1:0]    wr_data,
    input  logic                                        rel,
    input  logic [LOG_INPUT_NUM-1:0]                    rd_idx,
    output logic                                        full,
    output logic [DATA_WIDTH-1:0]                       rd_elem
);

    localparam int VEC_W = elem_count(LOG_INPUT_NUM) * DATA_WIDTH;

    logic [VEC_W-1:0] data_q, data_d;
    logic             full_q, full_d;

    // A write on the same edge as a release wins: the bank is refilled, not emptied.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (rel) begin
            full_d = 1'b0;
        end
        if (wr_en) begin
            data_d = wr_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign full    = full_q;
    assign rd_elem = data_q[int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/sorted_stream_unloader.sv
// Captures sorted vectors into two ping-pong banks and replays them as a
// valid/ready element stream. Optional out_idx port under SORT_UNLOAD_IDX_EN.
module sorted_stream_unloader
    import sort_net_pkg::*;
#(
    parameter int LOG_INPUT_NUM = LOG_INPUT_NUM_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int LSB_FIRST     = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    input  logic [(2**LOG_INPUT_NUM)*DATA_WIDTH-1:0]    in_data,
    output logic                                        in_ready,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [DATA_WIDTH-1:0]                       out_data,
    output logic                                        out_last,
`ifdef SORT_UNLOAD_IDX_EN
    output logic [LOG_INPUT_NUM-1:0]                    out_idx,
`endif
    output logic                                        overflow
);

    localparam logic [LOG_INPUT_NUM-1:0] CNT_ONE = 1;

    rd_state_t                  state_q, state_d;
    bank_sel_t                  wr_bank_q, wr_bank_d;
    bank_sel_t                  rd_bank_q, rd_bank_d;
    logic [LOG_INPUT_NUM-1:0]   elem_cnt_q, elem_cnt_d;
    logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;
    logic                       overflow_q, overflow_d;

    logic [1:0]                 bank_full;
    logic [1:0]                 bank_full_d;
    logic [1:0]                 bank_wr;
    logic [1:0]                 bank_rel;
    logic [DATA_WIDTH-1:0]      bank_elem [2];
    logic [LOG_INPUT_NUM-1:0]   rd_idx_d;
    logic                       hs;
    logic                       last_hs;
    logic                       wr_free;
    logic                       cap;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        unload_bank #(
            .LOG_INPUT_NUM (LOG_INPUT_NUM),
            .DATA_WIDTH    (DATA_WIDTH)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (bank_wr[b]),
            .wr_data (in_data),
            .rel     (bank_rel[b]),
            .rd_idx  (rd_idx_d),
            .full    (bank_full[b]),
            .rd_elem (bank_elem[b])
        );
    end

    assign out_valid = (state_q == RD_STREAM);
    assign out_last  = out_valid && (&elem_cnt_q);
    assign in_ready  = !(&bank_full);
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;

    always_comb begin
        hs       = out_valid && out_ready;
        last_hs  = hs && (&elem_cnt_q);

        bank_rel = '0;
        if (last_hs) begin
            bank_rel[rd_bank_q] = 1'b1;
        end

        // A bank released by this edge's last handshake can take the incoming vector.
        wr_free = !bank_full[wr_bank_q] || bank_rel[wr_bank_q];
        cap     = in_valid && wr_free;

        bank_wr = '0;
        if (cap) begin
            bank_wr[wr_bank_q] = 1'b1;
        end

        for (int b = 0; b < 2; b++) begin
            bank_full_d[b] = (bank_full[b] && !bank_rel[b]) || bank_wr[b];
        end

        wr_bank_d = wr_bank_q ^ cap;
        rd_bank_d = rd_bank_q ^ last_hs;

        elem_cnt_d = elem_cnt_q;
        if (last_hs) begin
            elem_cnt_d = '0;
        end else if (hs) begin
            elem_cnt_d = elem_cnt_q + CNT_ONE;
        end

        rd_idx_d = (LSB_FIRST != 0) ? elem_cnt_d : ~elem_cnt_d;

        // Preload the element that will be on display after this edge; when that
        // bank is being written right now its register is stale, so bypass from in_data.
        if (cap && (wr_bank_q == rd_bank_d)) begin
            out_data_d = in_data[int'(rd_idx_d)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            out_data_d = bank_elem[rd_bank_d];
        end

        overflow_d = overflow_q || (in_valid && !cap);
        state_d    = bank_full_d[rd_bank_d] ? RD_STREAM : RD_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RD_IDLE;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            elem_cnt_q <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            elem_cnt_q <= elem_cnt_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef SORT_UNLOAD_IDX_EN
    logic [LOG_INPUT_NUM-1:0] idx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= rd_idx_d;
        end
    end

    assign out_idx = idx_q;
`endif

endmodule

// File: tb/tb_sorted_stream_unloader.sv
// Scoreboard bench for sorted_stream_unloader: two instances (LSB-first and
// MSB-first) share stimulus; a vector-level model predicts accept/drop and beats.
module tb_sorted_stream_unloader;

    localparam int LOGN = 4;
    localparam int N    = 16;
    localparam int DW   = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [3:0]    idx;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic [N*DW-1:0] in_data = '0;
    logic            out_ready = 1'b0;

    logic            in_ready_l, out_valid_l, out_last_l, overflow_l;
    logic [DW-1:0]   out_data_l;
    logic            in_ready_m, out_valid_m, out_last_m, overflow_m;
    logic [DW-1:0]   out_data_m;
`ifdef SORT_UNLOAD_IDX_EN
    logic [3:0]      out_idx_l, out_idx_m;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: vectors held, beats taken from the oldest, sticky drop flag.
    int    occ = 0;
    int    consumed = 0;
    logic  ovf_m = 1'b0;
    logic  exp_valid = 1'b0;
    logic  exp_inrdy = 1'b1;
    logic  exp_ovf = 1'b0;
    beat_t q_l[$];
    beat_t q_m[$];

    always #5 clk = ~clk;

    sorted_stream_unloader #(.LOG_INPUT_NUM(LOGN), .DATA_WIDTH(DW), .LSB_FIRST(1)) dut_l (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_l),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l), .out_last(out_last_l),
`ifdef SORT_UNLOAD_IDX_EN
        .out_idx(out_idx_l),
`endif
        .overflow(overflow_l)
    );

    sorted_stream_unloader #(.LOG_INPUT_NUM(LOGN), .DATA_WIDTH(DW), .LSB_FIRST(0)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_m),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m), .out_last(out_last_m),
`ifdef SORT_UNLOAD_IDX_EN
        .out_idx(out_idx_m),
`endif
        .overflow(overflow_m)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; also advances the model across the coming edge.
    task automatic cycle(input logic iv, input logic [N*DW-1:0] d, input logic rdy);
        logic hs, last, free;
        beat_t b;
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        exp_valid = (occ > 0);
        exp_inrdy = (occ < 2);
        exp_ovf   = ovf_m;
        hs   = (occ > 0) && rdy;
        last = hs && (consumed == N-1);
        free = (occ < 2) || last;
        if (hs) begin
            if (last) begin
                occ--;
                consumed = 0;
            end else begin
                consumed++;
            end
        end
        if (iv) begin
            if (free) begin
                occ++;
                for (int j = 0; j < N; j++) begin
                    b.data = d[j*DW +: DW];
                    b.last = (j == N-1);
                    b.idx  = 4'(j);
                    q_l.push_back(b);
                    b.data = d[(N-1-j)*DW +: DW];
                    b.idx  = 4'(N-1-j);
                    q_m.push_back(b);
                end
            end else begin
                ovf_m = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_async_valid_lsb", {31'd0, out_valid_l}, 0);
        chk("rst_async_valid_msb", {31'd0, out_valid_m}, 0);
        chk("rst_out_data_lsb", out_data_l, 0);
        occ = 0;
        consumed = 0;
        ovf_m = 1'b0;
        q_l.delete();
        q_m.delete();
        exp_valid = 1'b0;
        exp_inrdy = 1'b1;
        exp_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [N*DW-1:0] rand_vec();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    task automatic drain();
        for (int t = 0; t < 200 && occ > 0; t++) cycle(1'b0, '0, 1'b1);
        chk("drain_done", occ, 0);
    endtask

    always @(negedge clk) begin
        beat_t b;
        chk("valid_lsb", {31'd0, out_valid_l}, {31'd0, exp_valid});
        chk("inrdy_lsb", {31'd0, in_ready_l}, {31'd0, exp_inrdy});
        chk("ovf_lsb", {31'd0, overflow_l}, {31'd0, exp_ovf});
        if (out_valid_l && out_ready) begin
            if (q_l.size() == 0) begin
                chk("beat_unexpected_lsb", 1, 0);
            end else begin
                b = q_l.pop_front();
                chk("data_lsb", out_data_l, b.data);
                chk("last_lsb", {31'd0, out_last_l}, {31'd0, b.last});
`ifdef SORT_UNLOAD_IDX_EN
                chk("idx_lsb", {28'd0, out_idx_l}, {28'd0, b.idx});
`endif
            end
        end
    end

    always @(negedge clk) begin
        beat_t b;
        chk("valid_msb", {31'd0, out_valid_m}, {31'd0, exp_valid});
        chk("ovf_msb", {31'd0, overflow_m}, {31'd0, exp_ovf});
        if (out_valid_m && out_ready) begin
            if (q_m.size() == 0) begin
                chk("beat_unexpected_msb", 1, 0);
            end else begin
                b = q_m.pop_front();
                chk("data_msb", out_data_m, b.data);
                chk("last_msb", {31'd0, out_last_m}, {31'd0, b.last});
`ifdef SORT_UNLOAD_IDX_EN
                chk("idx_msb", {28'd0, out_idx_m}, {28'd0, b.idx});
`endif
            end
        end
    end

    initial begin
        logic [N*DW-1:0] ramp;
        logic [N*DW-1:0] va, vb, vc;
        logic iv;
        for (int i = 0; i < N; i++) ramp[i*DW +: DW] = i;

        #2;
        chk("reset_valid", {31'd0, out_valid_l}, 0);
        chk("reset_last", {31'd0, out_last_l}, 0);
        chk("reset_data", out_data_l, 0);
        chk("reset_ovf", {31'd0, overflow_l}, 0);
        chk("reset_inrdy", {31'd0, in_ready_l}, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // ramp vector, consumer always ready
        cycle(1'b1, ramp, 1'b1);
        repeat (20) cycle(1'b0, '0, 1'b1);

        // two vectors back to back
        cycle(1'b1, rand_vec(), 1'b1);
        cycle(1'b1, rand_vec(), 1'b1);
        drain();

        // third vector lands on the edge that frees a bank
        va = rand_vec();
        vb = rand_vec();
        vc = rand_vec();
        cycle(1'b1, va, 1'b0);
        cycle(1'b1, vb, 1'b0);
        cycle(1'b0, '0, 1'b0);
        for (int t = 0; t < 40; t++) begin
            iv = (occ == 2) && (consumed == N-1);
            cycle(iv, vc, 1'b1);
            if (iv) break;
        end
        chk("exception_no_ovf", {31'd0, ovf_m}, 0);
        drain();

        // consumer stalled, third vector dropped
        cycle(1'b1, rand_vec(), 1'b0);
        cycle(1'b1, rand_vec(), 1'b0);
        cycle(1'b1, rand_vec(), 1'b0);
        repeat (5) cycle(1'b0, '0, 1'b0);
        chk("overflow_model", {31'd0, ovf_m}, 1);
        drain();
        repeat (3) cycle(1'b0, '0, 1'b1);

        // reset in the middle of a vector, then a fresh one
        do_reset();
        cycle(1'b1, rand_vec(), 1'b1);
        for (int t = 0; t < 40 && consumed != 7; t++) cycle(1'b0, '0, 1'b1);
        do_reset();
        cycle(1'b1, ramp, 1'b1);
        drain();

        // randomized traffic with backpressure
        for (int t = 0; t < 800; t++) begin
            cycle(($urandom_range(0, 3) == 0), rand_vec(), ($urandom_range(0, 9) < 7));
        end
        drain();
        repeat (2) cycle(1'b0, '0, 1'b1);

        chk("queue_empty_lsb", q_l.size(), 0);
        chk("queue_empty_msb", q_m.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
